// File: rtl/psum_ctrl_pkg.sv
// psum_ctrl_pkg: shared FSM/grant types and write-mask helper for the psum SRAM controller
package psum_ctrl_pkg;

    localparam int WMASK_MAX_W = 1024;

    typedef enum logic [2:0] {IDLE, ACC_RD, ACC_WR, DRN_RD, DRN_RSP} psum_state_e;

    typedef enum logic {GNT_ACC, GNT_DRN} grant_e;

    function automatic logic [WMASK_MAX_W-1:0] wmask_all(input int w);
        wmask_all = '0;
        for (int i = 0; i < w; i++) wmask_all[i] = 1'b1;
    endfunction

endpackage

// File: rtl/psum_adder.sv
// psum_adder: combinational signed psum add; wraps by default, saturates when PSUM_SAT_EN is defined
module psum_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] wrap;

    assign wrap = a_i + b_i;

`ifdef PSUM_SAT_EN
    logic ovf;
    assign ovf   = (a_i[W-1] == b_i[W-1]) && (wrap[W-1] != a_i[W-1]);
    assign sum_o = ovf ? {a_i[W-1], {(W-1){~a_i[W-1]}}} : wrap;
`else
    assign sum_o = wrap;
`endif

endmodule

// File: rtl/psum_ram_ctrl.sv
// psum_ram_ctrl: one psum SRAM bank shared by an accumulate (RMW) port and a drain port; PSUM_SAT_EN selects saturating accumulate
module psum_ram_ctrl
    import psum_ctrl_pkg::*;
#(
    parameter int ADR_W  = 12,
    parameter int SRAM_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_acc_valid,
    output logic              o_acc_ready,
    input  logic [ADR_W-1:0]  i_acc_addr,
    input  logic [SRAM_W-1:0] i_acc_data,
    input  logic              i_acc_first,
    input  logic              i_drn_valid,
    output logic              o_drn_ready,
    input  logic [ADR_W-1:0]  i_drn_addr,
    output logic              o_drn_rvalid,
    output logic [SRAM_W-1:0] o_drn_rdata,
    input  logic              i_drn_rready,
    output logic              o_cen,
    output logic              o_rdwen,
    output logic [ADR_W-1:0]  o_addr,
    output logic [SRAM_W-1:0] o_indata,
    output logic [SRAM_W-1:0] o_wmask,
    input  logic [SRAM_W-1:0] i_outdata,
    output logic              o_busy
);

    localparam logic [WMASK_MAX_W-1:0] WMASK_WIDE = wmask_all(SRAM_W);
    localparam logic [SRAM_W-1:0]      WMASK_ALL  = WMASK_WIDE[SRAM_W-1:0];

    psum_state_e       state_q, state_d;
    grant_e            prio_q, prio_d;
    logic              cen_q, cen_d, rdwen_q, rdwen_d, rvalid_q, rvalid_d;
    logic [ADR_W-1:0]  addr_q, addr_d;
    logic [SRAM_W-1:0] indata_q, indata_d, wmask_q, wmask_d, rdata_q, rdata_d, sum;
    logic              gnt_acc, gnt_drn;

    // indata_q holds the captured contribution during ACC_RD, so it doubles as the adder operand
    psum_adder #(.W(SRAM_W)) u_add (
        .a_i  (i_outdata),
        .b_i  (indata_q),
        .sum_o(sum)
    );

    assign gnt_acc      = (state_q == IDLE) && i_acc_valid && (!i_drn_valid || prio_q == GNT_ACC);
    assign gnt_drn      = (state_q == IDLE) && i_drn_valid && (!i_acc_valid || prio_q == GNT_DRN);
    assign o_acc_ready  = gnt_acc;
    assign o_drn_ready  = gnt_drn;
    assign o_busy       = state_q != IDLE;
    assign o_cen        = cen_q;
    assign o_rdwen      = rdwen_q;
    assign o_addr       = addr_q;
    assign o_indata     = indata_q;
    assign o_wmask      = wmask_q;
    assign o_drn_rvalid = rvalid_q;
    assign o_drn_rdata  = rdata_q;

    // next state plus RAM controls derived from the next state so they are registered
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        addr_d   = addr_q;
        indata_d = indata_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_acc) begin
                    state_d  = i_acc_first ? ACC_WR : ACC_RD;
                    addr_d   = i_acc_addr;
                    indata_d = i_acc_data;
                end else if (gnt_drn) begin
                    state_d = DRN_RD;
                    addr_d  = i_drn_addr;
                end
                if (i_acc_valid && i_drn_valid) prio_d = (prio_q == GNT_ACC) ? GNT_DRN : GNT_ACC;
            end
            ACC_RD: begin
                state_d  = ACC_WR;
                indata_d = sum;
            end
            ACC_WR: state_d = IDLE;
            DRN_RD: begin
                state_d  = DRN_RSP;
                rdata_d  = i_outdata;
                rvalid_d = 1'b1;
            end
            DRN_RSP: begin
                if (i_drn_rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        cen_d   = !(state_d inside {ACC_RD, ACC_WR, DRN_RD});
        rdwen_d = state_d != ACC_WR;
        wmask_d = (state_d == ACC_WR) ? WMASK_ALL : '0;
    end

    // state and RAM interface registers; async reset drops cen at once, aborting any write
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            prio_q   <= GNT_ACC;
            cen_q    <= 1'b1;
            rdwen_q  <= 1'b1;
            addr_q   <= '0;
            indata_q <= '0;
            wmask_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            cen_q    <= cen_d;
            rdwen_q  <= rdwen_d;
            addr_q   <= addr_d;
            indata_q <= indata_d;
            wmask_q  <= wmask_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_psum_ram_ctrl.sv
// tb_psum_ram_ctrl: directed + randomized bench for psum_ram_ctrl with a behavioural SRAM and psum memory model
module tb_psum_ram_ctrl;

    logic        clk, rstn;
    logic        acc_valid, acc_ready, acc_first;
    logic [11:0] acc_addr, drn_addr, addr;
    logic [31:0] acc_data, drn_rdata, indata, wmask, outdata;
    logic        drn_valid, drn_ready, drn_rvalid, drn_rready;
    logic        cen, rdwen, busy;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    int          n_chk, n_err;
    bit          acc_pri;

    psum_ram_ctrl dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_acc_valid(acc_valid), .o_acc_ready(acc_ready), .i_acc_addr(acc_addr),
        .i_acc_data(acc_data), .i_acc_first(acc_first),
        .i_drn_valid(drn_valid), .o_drn_ready(drn_ready), .i_drn_addr(drn_addr),
        .o_drn_rvalid(drn_rvalid), .o_drn_rdata(drn_rdata), .i_drn_rready(drn_rready),
        .o_cen(cen), .o_rdwen(rdwen), .o_addr(addr), .o_indata(indata), .o_wmask(wmask),
        .i_outdata(outdata), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: byte-masked write on the edge; read data presented while a read is on the bus, junk otherwise
    always @(posedge clk) begin
        if (!cen && !rdwen)
            for (int k = 0; k < 4; k++)
                if (wmask[8*k]) mem[addr][8*k +: 8] <= indata[8*k +: 8];
    end
    assign outdata = (!cen && rdwen) ? mem[addr] : 32'hA5A5_5A5A;

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_SAT_EN
        if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
        if (s < -64'sh8000_0000) s = -64'sh8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic acc_op(input logic [11:0] a, input logic [31:0] d, input logic f);
        logic [31:0] e;
        e = f ? d : ref_add(ref_mem[a], d);
        acc_valid = 1; acc_addr = a; acc_data = d; acc_first = f;
        @(negedge clk);
        check("acc_ready", 32'(acc_ready), 1);
        check("acc_drn_ready", 32'(drn_ready), 0);
        @(posedge clk); #1;
        acc_valid = 0; acc_data = $urandom; acc_addr = 12'($urandom);
        @(negedge clk);
        if (!f) begin
            check("accrd_cen", 32'(cen), 0);
            check("accrd_rdwen", 32'(rdwen), 1);
            check("accrd_addr", 32'(addr), 32'(a));
            @(negedge clk);
        end
        check("accwr_cen", 32'(cen), 0);
        check("accwr_rdwen", 32'(rdwen), 0);
        check("accwr_addr", 32'(addr), 32'(a));
        check("accwr_indata", indata, e);
        check("accwr_wmask", wmask, 32'hFFFF_FFFF);
        check("accwr_busy", 32'(busy), 1);
        @(negedge clk);
        check("acc_end_cen", 32'(cen), 1);
        check("acc_end_busy", 32'(busy), 0);
        ref_mem[a] = e;
        check("acc_mem", mem[a], e);
        @(posedge clk); #1;
    endtask

    task automatic drn_op(input logic [11:0] a, input int hold);
        logic [31:0] e;
        e = ref_mem[a];
        drn_valid = 1; drn_addr = a;
        @(negedge clk);
        check("drn_ready", 32'(drn_ready), 1);
        check("drn_acc_ready", 32'(acc_ready), 0);
        @(posedge clk); #1;
        drn_valid = 0; drn_addr = 12'($urandom);
        @(negedge clk);
        check("drnrd_cen", 32'(cen), 0);
        check("drnrd_rdwen", 32'(rdwen), 1);
        check("drnrd_addr", 32'(addr), 32'(a));
        check("drnrd_rvalid", 32'(drn_rvalid), 0);
        @(negedge clk);
        check("drn_rvalid", 32'(drn_rvalid), 1);
        check("drn_rdata", drn_rdata, e);
        check("drnrsp_cen", 32'(cen), 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            drn_valid = 1;
            @(negedge clk);
            check("hold_rvalid", 32'(drn_rvalid), 1);
            check("hold_rdata", drn_rdata, e);
            check("hold_cen", 32'(cen), 1);
            check("hold_drn_ready", 32'(drn_ready), 0);
        end
        @(posedge clk); #1;
        drn_valid = 0; drn_rready = 1;
        @(negedge clk);
        check("hs_rvalid", 32'(drn_rvalid), 1);
        @(posedge clk); #1;
        drn_rready = 0;
        @(negedge clk);
        check("post_rvalid", 32'(drn_rvalid), 0);
        check("post_busy", 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          n, ngd, nrsp;
        logic [31:0] exp_rd;
        int          wq[$];
        n_chk = 0; n_err = 0; acc_pri = 1;
        rstn = 0; acc_valid = 0; acc_first = 0; acc_addr = 0; acc_data = 0;
        drn_valid = 0; drn_addr = 0; drn_rready = 0; exp_rd = 0;
        #12;
        check("rst_cen", 32'(cen), 1);
        check("rst_rdwen", 32'(rdwen), 1);
        check("rst_addr", 32'(addr), 0);
        check("rst_indata", indata, 0);
        check("rst_wmask", wmask, 0);
        check("rst_rvalid", 32'(drn_rvalid), 0);
        check("rst_rdata", drn_rdata, 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk); rstn = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_cen", 32'(cen), 1);
            check("idle_busy", 32'(busy), 0);
        end
        @(posedge clk); #1;
        for (int i = 16; i < 24; i++) acc_op(12'(i), $urandom, 1);
        acc_op(5, 10, 1);
        acc_op(5, 7, 0);
        check("tp_mem5", mem[5], 17);
        drn_op(5, 0);
        drn_op(16, 4);
        acc_op(0, 32'h7FFF_FFFF, 1);
        acc_op(0, 1, 0);
`ifdef PSUM_SAT_EN
        check("ovf_pos", mem[0], 32'h7FFF_FFFF);
`else
        check("ovf_pos", mem[0], 32'h8000_0000);
`endif
        acc_op(1, 32'h8000_0000, 1);
        acc_op(1, 32'hFFFF_FFFF, 0);
`ifdef PSUM_SAT_EN
        check("ovf_neg", mem[1], 32'h8000_0000);
`else
        check("ovf_neg", mem[1], 32'h7FFF_FFFF);
`endif
        acc_first = 1; acc_valid = 1; drn_valid = 1; drn_rready = 1;
        acc_addr = 12'(100 + $urandom_range(7)); acc_data = $urandom;
        drn_addr = 12'(16 + $urandom_range(7));
        ngd = 0; nrsp = 0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            @(negedge clk);
            while (busy && n < 10) begin
                if (drn_rvalid) begin check("alt_rdata", drn_rdata, exp_rd); nrsp++; end
                @(negedge clk); n++;
            end
            check("alt_idle", 32'(busy), 0);
            check("alt_acc_ready", 32'(acc_ready), 32'(acc_pri));
            check("alt_drn_ready", 32'(drn_ready), 32'(!acc_pri));
            if (acc_pri) begin ref_mem[acc_addr] = acc_data; wq.push_back(int'(acc_addr)); end
            else begin exp_rd = ref_mem[drn_addr]; ngd++; end
            @(posedge clk); #1;
            if (acc_pri) begin acc_addr = 12'(100 + $urandom_range(7)); acc_data = $urandom; end
            else drn_addr = 12'(16 + $urandom_range(7));
            acc_pri = !acc_pri;
        end
        acc_valid = 0; drn_valid = 0;
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin
            if (drn_rvalid) begin check("alt_rdata", drn_rdata, exp_rd); nrsp++; end
            @(negedge clk); n++;
        end
        check("alt_drain_idle", 32'(busy), 0);
        check("alt_rsp_count", 32'(nrsp), 32'(ngd));
        foreach (wq[i]) check("alt_mem", mem[wq[i]], ref_mem[wq[i]]);
        drn_rready = 0;
        @(posedge clk); #1;
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(1) == 1) acc_op(12'(16 + $urandom_range(7)), $urandom, 1'($urandom_range(1)));
            else drn_op(12'(16 + $urandom_range(7)), int'($urandom_range(3)));
        end
        acc_valid = 1; acc_addr = 16; acc_data = 32'h1234; acc_first = 0;
        @(negedge clk);
        check("rstw_ready", 32'(acc_ready), 1);
        @(posedge clk); #1;
        acc_valid = 0;
        @(posedge clk); #1;
        check("rstw_pre_cen", 32'(cen), 0);
        check("rstw_pre_rdwen", 32'(rdwen), 0);
        rstn = 0; #1;
        check("rstw_cen", 32'(cen), 1);
        check("rstw_rdwen", 32'(rdwen), 1);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_wmask", wmask, 0);
        @(posedge clk); #1;
        check("rstw_mem", mem[16], ref_mem[16]);
        check("rstw_rvalid", 32'(drn_rvalid), 0);
        @(negedge clk); rstn = 1; acc_pri = 1;
        @(posedge clk); #1;
        acc_op(16, 32'h55, 0);
        drn_op(16, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
